// File: rtl/serial_addsub_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract sequencer.
//   state_e : 2-bit controller state encoding (one code left unused)
//   OP_ADD  : op value selecting A + B
//   OP_SUB  : op value selecting A - B (computed as A + ~B + 1)
package serial_addsub_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/adder_1bit.sv
// Single full-adder cell, the only arithmetic element of the serial datapath.
//   a, b : operand bits
//   ci   : carry in
//   s    : sum bit
//   c0   : carry out
module adder_1bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic c0
);

    assign s  = a ^ b ^ ci;
    assign c0 = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial WIDTH-bit adder/subtractor built around one adder_1bit cell.
// Operands are processed LSB first, one bit per clock, with the carry held
// in a flop between cycles. start/busy/done handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request pulse, sampled only in IDLE
//   op         : 0 = A+B, 1 = A-B, sampled with start
//   a, b       : operands, sampled with start
//   busy       : high in RUN and DONE
//   done       : one-cycle pulse, result valid
//   result     : sum/difference, held until next accepted start
//   cout       : raw carry out of MSB (subtract: 1 = no borrow)
//   ovf        : two's-complement overflow
module serial_addsub_ctrl
    import serial_addsub_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sa_q, sa_d;
    logic [WIDTH-1:0]   sb_q, sb_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               cell_s, cell_c;
    logic               accept;
    logic               last_bit;

    adder_1bit u_cell (
        .a  (sa_q[0]),
        .b  (sb_q[0]),
        .ci (carry_q),
        .s  (cell_s),
        .c0 (cell_c)
    );

    assign accept   = (state_q == ST_IDLE) && start;
    assign last_bit = (cnt_q == LAST_BIT);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the unused code falls back to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)    state_d = ST_RUN;
            ST_RUN:  if (last_bit) state_d = ST_DONE;
            ST_DONE:               state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            ST_RUN:  busy = 1'b1;
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath next values. Subtract preloads carry=1 and inverts B so the
    // cell computes A + ~B + 1. On the last bit, carry_q is the carry into the
    // MSB, so XOR with the cell carry-out gives signed overflow.
    always_comb begin
        sa_d     = sa_q;
        sb_d     = sb_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        if (accept) begin
            sa_d    = a;
            sb_d    = b ^ {WIDTH{op}};
            carry_d = (op == OP_SUB);
            cnt_d   = '0;
        end else if (state_q == ST_RUN) begin
            result_d = {cell_s, result_q[WIDTH-1:1]};
            sa_d     = sa_q >> 1;
            sb_d     = sb_q >> 1;
            carry_d  = cell_c;
            cnt_d    = cnt_q + CNT_W'(1);
            if (last_bit) begin
                cout_d = cell_c;
                ovf_d  = carry_q ^ cell_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_q     <= '0;
            sb_q     <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
module tb_serial_addsub_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start8, op8, busy8, done8, cout8, ovf8;
    logic [7:0] a8, b8, res8;
    logic       start2, op2, busy2, done2, cout2, ovf2;
    logic [1:0] a2, b2, res2;

    int checks = 0;
    int passed = 0;

    serial_addsub_ctrl #(.WIDTH(8)) dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start8),
        .op     (op8),
        .a      (a8),
        .b      (b8),
        .busy   (busy8),
        .done   (done8),
        .result (res8),
        .cout   (cout8),
        .ovf    (ovf8)
    );

    serial_addsub_ctrl #(.WIDTH(2)) dut2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start2),
        .op     (op2),
        .a      (a2),
        .b      (b2),
        .busy   (busy2),
        .done   (done2),
        .result (res2),
        .cout   (cout2),
        .ovf    (ovf2)
    );

    // Launch one WIDTH=8 operation; lat = edges from start edge to done, -1 on timeout
    task automatic run8(input logic o, input logic [7:0] av, input logic [7:0] bv, output int lat);
        @(posedge clk); #1;
        op8 = o; a8 = av; b8 = bv; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done8) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start8 = 1'b0; op8 = 1'b0; a8 = '0; b8 = '0;
        start2 = 1'b0; op2 = 1'b0; a2 = '0; b2 = '0;
        #12;
        checks++;
        if ({busy8, done8, res8, cout8, ovf8} !== 12'h000)
            $display("FAIL reset_w8 got=%h exp=000", {busy8, done8, res8, cout8, ovf8});
        else passed++;
        checks++;
        if ({busy2, done2, res2, cout2, ovf2} !== 6'h00)
            $display("FAIL reset_w2 got=%h exp=00", {busy2, done2, res2, cout2, ovf2});
        else passed++;
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_handshake;
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_edge = -1;
        @(posedge clk); #1;
        op8 = 1'b0; a8 = 8'h5A; b8 = 8'h33; start8 = 1'b1;
        for (int e = 0; e <= 11; e++) begin
            @(posedge clk); #1;
            if (e == 0) start8 = 1'b0;
            if (busy8) busy_cnt++;
            if (done8) begin
                done_cnt++;
                done_edge = e;
            end
        end
        checks++;
        if (busy_cnt !== 9) $display("FAIL hs_busy_cycles got=%0d exp=9", busy_cnt);
        else passed++;
        checks++;
        if (done_cnt !== 1) $display("FAIL hs_done_pulses got=%0d exp=1", done_cnt);
        else passed++;
        checks++;
        if (done_edge !== 8) $display("FAIL hs_done_edge got=%0d exp=8", done_edge);
        else passed++;
        checks++;
        if ({res8, cout8, ovf8} !== {8'h8D, 1'b0, 1'b1})
            $display("FAIL hs_5A+33 got=%h exp=%h", {res8, cout8, ovf8}, {8'h8D, 1'b0, 1'b1});
        else passed++;
    endtask

    task automatic test_add_sub;
        logic       ov [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [7:0] av [5] = '{8'hFF, 8'h7F, 8'h10, 8'h80, 8'h33};
        logic [7:0] bv [5] = '{8'h01, 8'h01, 8'h20, 8'h01, 8'h33};
        // {result, cout, ovf}
        logic [9:0] ex [5] = '{10'h002, 10'h201, 10'h3C0, 10'h1FF, 10'h002};
        int lat;
        for (int k = 0; k < 5; k++) begin
            run8(ov[k], av[k], bv[k], lat);
            checks++;
            if (lat !== 8) $display("FAIL op%0d_latency got=%0d exp=8", k, lat);
            else passed++;
            checks++;
            if ({res8, cout8, ovf8} !== ex[k])
                $display("FAIL op%0d_value got=%h exp=%h", k, {res8, cout8, ovf8}, ex[k]);
            else passed++;
        end
    endtask

    task automatic test_back_to_back;
        int done_cnt = 0;
        int done_edge = -1;
        int lat = -1;
        @(posedge clk); #1;
        op8 = 1'b0; a8 = 8'h11; b8 = 8'h22; start8 = 1'b1;
        for (int e = 0; e <= 9; e++) begin
            @(posedge clk); #1;
            if (done8) begin
                done_cnt++;
                done_edge = e;
            end
            case (e)
                0: start8 = 1'b0;
                3: begin
                    a8 = 8'hF0; b8 = 8'h0F; op8 = 1'b1; start8 = 1'b1;
                end
                4: start8 = 1'b0;
                8: start8 = 1'b1;
                default: ;
            endcase
        end
        // now just after edge 9; start still high for edge 10
        checks++;
        if (done_cnt !== 1) $display("FAIL b2b_done_pulses got=%0d exp=1", done_cnt);
        else passed++;
        checks++;
        if (done_edge !== 8) $display("FAIL b2b_done_edge got=%0d exp=8", done_edge);
        else passed++;
        checks++;
        if (busy8 !== 1'b0) $display("FAIL b2b_idle_after_done got=%b exp=0", busy8);
        else passed++;
        checks++;
        if ({res8, cout8, ovf8} !== {8'h33, 1'b0, 1'b0})
            $display("FAIL b2b_11+22 got=%h exp=%h", {res8, cout8, ovf8}, {8'h33, 1'b0, 1'b0});
        else passed++;
        @(posedge clk); #1;
        start8 = 1'b0;
        checks++;
        if (busy8 !== 1'b1) $display("FAIL b2b_accept_edge10 got=%b exp=1", busy8);
        else passed++;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done8) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (lat !== 8) $display("FAIL b2b_second_latency got=%0d exp=8", lat);
        else passed++;
        checks++;
        if ({res8, cout8, ovf8} !== {8'hE1, 1'b1, 1'b0})
            $display("FAIL b2b_F0-0F got=%h exp=%h", {res8, cout8, ovf8}, {8'hE1, 1'b1, 1'b0});
        else passed++;
    endtask

    task automatic test_reset_mid;
        logic done_seen = 1'b0;
        int lat;
        @(posedge clk); #1;
        op8 = 1'b0; a8 = 8'h5A; b8 = 8'h33; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        checks++;
        if (busy8 !== 1'b1) $display("FAIL rst_mid_was_busy got=%b exp=1", busy8);
        else passed++;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy8, done8, res8, cout8, ovf8} !== 12'h000)
            $display("FAIL rst_mid_outputs got=%h exp=000", {busy8, done8, res8, cout8, ovf8});
        else passed++;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            done_seen = done_seen | done8;
        end
        #3 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            done_seen = done_seen | done8;
        end
        checks++;
        if (done_seen !== 1'b0) $display("FAIL rst_mid_no_done got=%b exp=0", done_seen);
        else passed++;
        run8(1'b0, 8'h01, 8'h01, lat);
        checks++;
        if (lat !== 8) $display("FAIL rst_mid_after_latency got=%0d exp=8", lat);
        else passed++;
        checks++;
        if ({res8, cout8, ovf8} !== {8'h02, 1'b0, 1'b0})
            $display("FAIL rst_mid_01+01 got=%h exp=%h", {res8, cout8, ovf8}, {8'h02, 1'b0, 1'b0});
        else passed++;
    endtask

    task automatic test_width2;
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_edge = -1;
        @(posedge clk); #1;
        op2 = 1'b0; a2 = 2'b11; b2 = 2'b01; start2 = 1'b1;
        for (int e = 0; e <= 5; e++) begin
            @(posedge clk); #1;
            if (e == 0) start2 = 1'b0;
            if (busy2) busy_cnt++;
            if (done2) begin
                done_cnt++;
                done_edge = e;
            end
        end
        checks++;
        if (done_edge !== 2) $display("FAIL w2_done_edge got=%0d exp=2", done_edge);
        else passed++;
        checks++;
        if (done_cnt !== 1) $display("FAIL w2_done_pulses got=%0d exp=1", done_cnt);
        else passed++;
        checks++;
        if (busy_cnt !== 3) $display("FAIL w2_busy_cycles got=%0d exp=3", busy_cnt);
        else passed++;
        checks++;
        if ({res2, cout2, ovf2} !== 4'b0010)
            $display("FAIL w2_11+01 got=%b exp=0010", {res2, cout2, ovf2});
        else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_handshake;
        test_add_sub;
        test_back_to_back;
        test_reset_mid;
        test_width2;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
